// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the per-channel AXI-Stream inputs and the serializer byte interface
// shared by the UART TX arbiter and whatever drives it.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_BITS = 8
);
    logic [NUM_CH*DATA_BITS-1:0] s_axis_tdata;
    logic [NUM_CH-1:0]           s_axis_tvalid;
    logic [NUM_CH-1:0]           s_axis_tlast;
    logic [NUM_CH-1:0]           s_axis_tready;
    logic [DATA_BITS-1:0]        tx_data;
    logic                        tx_start;
    logic                        tx_busy;
    logic [NUM_CH-1:0]           grant;
    logic                        active;
    logic                        ack_err;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, tx_busy,
        output s_axis_tready, tx_data, tx_start, grant, active, ack_err
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, tx_busy,
        input  s_axis_tready, tx_data, tx_start, grant, active, ack_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX serializer between
// NUM_CH AXI-Stream byte sources, with an optional channel-ID header byte.
module uart_tx_arbiter #(
    parameter int unsigned          NUM_CH      = 4,
    parameter int unsigned          DATA_BITS   = 8,
    parameter bit                   ID_HEADER   = 1'b1,
    parameter logic [DATA_BITS-1:0] HDR_BASE    = 8'hA0,
    parameter int unsigned          ACK_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_arbiter_if.slave       bus
);
    localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CH-1:0]    grant_q, grant_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        last_q, last_d;
    logic                 active_q, active_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 ack_err_q, ack_err_d;
    logic                 last_flag_q, last_flag_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 arb_found;
    logic [IW-1:0]        arb_idx;
    logic [DATA_BITS-1:0] sel_tdata;
    logic                 sel_tvalid;
    logic                 sel_tlast;

    // Rotating search starting just after the previous owner.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            logic [IW-1:0] cand;
            cand = IW'((32'(last_q) + 32'd1 + i) % NUM_CH);
            if (!arb_found && bus.s_axis_tvalid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_tdata  = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (idx_q == IW'(c)) begin
                sel_tdata  = bus.s_axis_tdata[c*DATA_BITS +: DATA_BITS];
                sel_tvalid = bus.s_axis_tvalid[c];
                sel_tlast  = bus.s_axis_tlast[c];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        last_d      = last_q;
        active_d    = active_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        ack_err_d   = 1'b0;
        last_flag_d = last_flag_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                    idx_d            = arb_idx;
                    active_d         = 1'b1;
                    state_d          = ID_HEADER ? S_HDR : S_LOAD;
                end
            end
            S_HDR: begin
                tx_data_d   = HDR_BASE | DATA_BITS'(idx_q);
                tx_start_d  = 1'b1;
                last_flag_d = 1'b0;
                cnt_d       = '0;
                state_d     = S_WAIT_HI;
            end
            S_LOAD: begin
                if (sel_tvalid) begin
                    tx_data_d   = sel_tdata;
                    tx_start_d  = 1'b1;
                    last_flag_d = sel_tlast;
                    cnt_d       = '0;
                    state_d     = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                // A serializer that never acknowledges is treated as having sent the byte.
                if (bus.tx_busy) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_LO;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    ack_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_WAIT_LO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    if (last_flag_q) begin
                        last_d   = idx_q;
                        grant_d  = '0;
                        active_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            idx_q       <= '0;
            last_q      <= IW'(NUM_CH - 1);
            active_q    <= 1'b0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            ack_err_q   <= 1'b0;
            last_flag_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            active_q    <= active_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            ack_err_q   <= ack_err_d;
            last_flag_q <= last_flag_d;
            cnt_q       <= cnt_d;
        end
    end

    // Only the owner sees ready, and only while no byte is outstanding.
    assign bus.s_axis_tready = (state_q == S_LOAD) ? grant_q : '0;
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_start      = tx_start_q;
    assign bus.grant         = grant_q;
    assign bus.active        = active_q;
    assign bus.ack_err       = ack_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of single-packet transfers plus
// hand-written contention, stall, timeout and mid-packet reset sequences.
module tb_uart_tx_arbiter;
    localparam int NUM_CH = 4;
    localparam int DB     = 8;
    localparam int BUSY   = 10;
    localparam int TO     = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_CH(NUM_CH), .DATA_BITS(DB)) bus();

    uart_tx_arbiter #(
        .NUM_CH(NUM_CH), .DATA_BITS(DB), .ID_HEADER(1'b1),
        .HDR_BASE(8'hA0), .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef logic [8:0] beat_q_t[$];
    beat_q_t chq [NUM_CH];

    typedef struct {
        int          ch;
        int          len;
        logic [31:0] bytes;
        logic [7:0]  hdr;
        logic [3:0]  gnt;
    } vec_t;
    vec_t vt [4];

    int errors = 0, checks = 0;
    int cyc = 0;
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    int         ack_cyc[$];
    logic [3:0] grant_seq[$];
    logic [3:0] prev_grant = '0, grant_or = '0, hold = '0;
    int  dbl_start = 0, dbl_ack = 0, tready_leak = 0, first_grant_cyc = -1;
    logic prev_start = 1'b0, prev_ack = 1'b0, ser_en = 1'b1;
    int  busy_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        logic [NUM_CH-1:0]    v, l;
        logic [NUM_CH*DB-1:0] d;
        v = '0; l = '0; d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (chq[c].size() > 0 && !hold[c]) begin
                v[c]          = 1'b1;
                l[c]          = chq[c][0][8];
                d[c*DB +: DB] = chq[c][0][7:0];
            end
        end
        bus.s_axis_tvalid = v;
        bus.s_axis_tlast  = l;
        bus.s_axis_tdata  = d;
        bus.tx_busy       = (busy_cnt > 0);
    endtask

    // One clock: observe at the falling edge, then update sources after the rising edge.
    task automatic tick();
        logic [NUM_CH-1:0] hs;
        logic st;
        @(negedge clk);
        hs = bus.s_axis_tvalid & bus.s_axis_tready;
        st = bus.tx_start;
        if (bus.tx_start) begin
            tx_log.push_back(bus.tx_data);
            tx_cyc.push_back(cyc);
            if (prev_start) dbl_start++;
        end
        prev_start = bus.tx_start;
        if (bus.ack_err) begin
            ack_cyc.push_back(cyc);
            if (prev_ack) dbl_ack++;
        end
        prev_ack = bus.ack_err;
        if ((bus.s_axis_tready & ~bus.grant) != '0) tready_leak++;
        if (bus.active) grant_or |= bus.grant;
        if (bus.grant != '0 && first_grant_cyc < 0) first_grant_cyc = cyc;
        if (bus.grant != prev_grant && bus.grant != '0) grant_seq.push_back(bus.grant);
        prev_grant = bus.grant;
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < NUM_CH; c++)
            if (hs[c]) void'(chq[c].pop_front());
        if (ser_en && st) busy_cnt = BUSY;
        else if (busy_cnt > 0) busy_cnt--;
        refresh();
    endtask

    task automatic clr();
        tx_log.delete(); tx_cyc.delete(); ack_cyc.delete(); grant_seq.delete();
        grant_or = '0; first_grant_cyc = -1;
    endtask

    task automatic push(input int ch, input logic [7:0] b, input logic last);
        chq[ch].push_back({last, b});
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int c = 0; c < NUM_CH; c++) if (chq[c].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic run_idle(input string name, input int budget);
        int n = 0;
        while ((pending() || bus.active) && n < budget) begin
            tick();
            n++;
        end
        chk({name, " completes in budget"}, 32'(n < budget), 1);
    endtask

    task automatic chk_log(input string name, input logic [7:0] exp[$]);
        chk({name, " tx count"}, tx_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (i < tx_log.size()) chk($sformatf("%s tx[%0d]", name, i), tx_log[i], exp[i]);
    endtask

    task automatic chk_grants(input string name, input logic [3:0] exp[$]);
        chk({name, " grant count"}, grant_seq.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (i < grant_seq.size()) chk($sformatf("%s grant[%0d]", name, i), grant_seq[i], exp[i]);
    endtask

    initial begin
        logic [7:0] exp_b[$];
        logic [3:0] exp_g[$];
        int p, n, gap_bad;

        vt[0] = '{2, 3, 32'h0033_2211, 8'hA2, 4'b0100};
        vt[1] = '{0, 1, 32'h0000_005A, 8'hA0, 4'b0001};
        vt[2] = '{3, 2, 32'h0000_00FF, 8'hA3, 4'b1000};
        vt[3] = '{1, 4, 32'h0804_0201, 8'hA1, 4'b0010};

        rst = 1'b1;
        refresh();
        tick(); tick();
        chk("reset grant",    bus.grant,         0);
        chk("reset active",   bus.active,        0);
        chk("reset tx_start", bus.tx_start,      0);
        chk("reset tx_data",  bus.tx_data,       0);
        chk("reset ack_err",  bus.ack_err,       0);
        chk("reset tready",   bus.s_axis_tready, 0);
        rst = 1'b0;
        tick();

        // Single-packet table
        for (int k = 0; k < 4; k++) begin
            logic [31:0] bv;
            bv = vt[k].bytes;
            clr();
            for (int b = 0; b < vt[k].len; b++) push(vt[k].ch, bv[8*b +: 8], b == vt[k].len - 1);
            refresh();
            p = cyc;
            run_idle($sformatf("v%0d", k), 200);
            exp_b.delete();
            exp_b.push_back(vt[k].hdr);
            for (int b = 0; b < vt[k].len; b++) exp_b.push_back(bv[8*b +: 8]);
            chk_log($sformatf("v%0d", k), exp_b);
            chk($sformatf("v%0d grant latency", k), first_grant_cyc - p, 1);
            if (tx_cyc.size() > 0) chk($sformatf("v%0d start latency", k), tx_cyc[0] - p, 2);
            chk($sformatf("v%0d grant held", k), grant_or, vt[k].gnt);
            chk($sformatf("v%0d grant released", k), bus.grant, 0);
            chk($sformatf("v%0d active released", k), bus.active, 0);
        end

        // Simultaneous ch0/ch3 requests after reset, two rounds
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int r = 0; r < 2; r++) begin
            clr();
            push(0, 8'h50 + 8'(r), 1'b1);
            push(3, 8'h53 + 8'(r), 1'b1);
            refresh();
            run_idle($sformatf("rr%0d", r), 300);
            exp_b = '{8'hA0, 8'h50 + 8'(r), 8'hA3, 8'h53 + 8'(r)};
            chk_log($sformatf("rr%0d", r), exp_b);
            exp_g = '{4'b0001, 4'b1000};
            chk_grants($sformatf("rr%0d", r), exp_g);
        end

        // ch0 arrives while ch1 owns a 4-byte packet
        clr();
        for (int b = 0; b < 4; b++) push(1, 8'h31 + 8'(b), b == 3);
        refresh();
        n = 0;
        while (chq[1].size() != 3 && n < 100) begin tick(); n++; end
        chk("hold first beat taken", 32'(chq[1].size()), 3);
        push(0, 8'h40, 1'b1);
        refresh();
        run_idle("hold", 400);
        exp_b = '{8'hA1, 8'h31, 8'h32, 8'h33, 8'h34, 8'hA0, 8'h40};
        chk_log("hold", exp_b);
        exp_g = '{4'b0010, 4'b0001};
        chk_grants("hold", exp_g);

        // ch1 stalls 20 cycles mid-packet
        clr();
        for (int b = 0; b < 4; b++) push(1, 8'h41 + 8'(b), b == 3);
        refresh();
        n = 0;
        while (chq[1].size() != 3 && n < 100) begin tick(); n++; end
        hold[1] = 1'b1;
        refresh();
        gap_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.grant != 4'b0010) gap_bad++;
        end
        chk("gap grant kept", gap_bad, 0);
        chk("gap no tx_start", tx_log.size(), 2);
        hold[1] = 1'b0;
        refresh();
        run_idle("gap", 400);
        exp_b = '{8'hA1, 8'h41, 8'h42, 8'h43, 8'h44};
        chk_log("gap", exp_b);
        exp_g = '{4'b0010};
        chk_grants("gap", exp_g);

        // Serializer never acknowledges
        ser_en = 1'b0;
        clr();
        push(2, 8'h51, 1'b0);
        push(2, 8'h52, 1'b1);
        refresh();
        run_idle("timeout", 400);
        exp_b = '{8'hA2, 8'h51, 8'h52};
        chk_log("timeout", exp_b);
        chk("timeout ack count", ack_cyc.size(), 3);
        for (int i = 0; i < ack_cyc.size(); i++)
            if (i < tx_cyc.size()) chk($sformatf("timeout ack[%0d] delay", i), ack_cyc[i] - tx_cyc[i], TO);
        chk("timeout ack single pulse", dbl_ack, 0);
        ser_en = 1'b1;

        // Reset while byte 2 of a 4-byte ch1 packet is on the wire
        clr();
        for (int b = 0; b < 4; b++) push(1, 8'h61 + 8'(b), b == 3);
        refresh();
        n = 0;
        while (tx_log.size() != 3 && n < 200) begin tick(); n++; end
        chk("rst reached byte 2", tx_log.size(), 3);
        tick(); tick(); tick();
        chk("rst serializer busy", bus.tx_busy, 1);
        rst = 1'b1;
        tick();
        chk("rst mid grant",    bus.grant,         0);
        chk("rst mid active",   bus.active,        0);
        chk("rst mid tx_start", bus.tx_start,      0);
        chk("rst mid tready",   bus.s_axis_tready, 0);
        chq[1].delete();
        refresh();
        rst = 1'b0;
        n = 0;
        while (bus.tx_busy && n < 30) begin tick(); n++; end
        chk("rst serializer drained", bus.tx_busy, 0);
        clr();
        push(3, 8'h73, 1'b1);
        push(1, 8'h71, 1'b1);
        refresh();
        run_idle("post-rst", 300);
        exp_b = '{8'hA1, 8'h71, 8'hA3, 8'h73};
        chk_log("post-rst", exp_b);
        exp_g = '{4'b0010, 4'b1000};
        chk_grants("post-rst", exp_g);

        chk("single-cycle tx_start", dbl_start, 0);
        chk("tready only to owner", tready_leak, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_CH AXI-Stream byte sources.
- Round-robin arbitration at packet granularity. The grant is held from the first beat until the beat with tlast has been transmitted.
- Optionally prefixes each packet with a channel-ID header byte so the far end can demultiplex.
- Sits between the per-channel AXIS producers and the UART TX serializer (tx_start/tx_busy byte interface).

Parameters:
- NUM_CH, 4, number of AXIS requesters (2..8).
- DATA_BITS, 8, byte width; must match the serializer.
- ID_HEADER, 1, 1 = send a header byte before each packet; 0 = payload only.
- HDR_BASE, 8'hA0, header byte = HDR_BASE | channel index; low 3 bits must be zero.
- ACK_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  NUM_CH*DATA_BITS  channel i occupies bits [i*DATA_BITS +: DATA_BITS]
- s_axis_tvalid  in  NUM_CH  per-channel valid
- s_axis_tlast  in  NUM_CH  per-channel end of packet
- s_axis_tready  out  NUM_CH  per-channel ready (combinational)
- tx_data  out  DATA_BITS  byte to serializer (registered)
- tx_start  out  1  one-cycle start pulse (registered)
- tx_busy  in  1  serializer busy
- grant  out  NUM_CH  one-hot owner of the transmitter; 0 when idle
- active  out  1  packet in progress
- ack_err  out  1  one-cycle pulse on ACK timeout

Behaviour:
- Reset (synchronous, takes priority in any state, including mid-packet):
  - state=IDLE; outputs grant=0, active=0, tx_start=0, tx_data=0, ack_err=0.
  - Round-robin pointer last=NUM_CH-1, so ch0 has highest priority first. Timeout counter=0.
  - A byte already handed to the serializer is not recalled.
- State machine:
  - IDLE: if any tvalid, pick the first asserted channel searching last+1, last+2, … (mod NUM_CH). Register grant one-hot and set active=1. Go to HDR if ID_HEADER else LOAD. If no tvalid, stay.
  - HDR: register tx_data=HDR_BASE|idx and tx_start=1. Clear last_flag. Go to WAIT_HI.
  - LOAD: s_axis_tready[g]=1 for the granted channel only; all others 0.
    - On tvalid[g]: register tx_data=tdata[g], tx_start=1, last_flag=tlast[g]. Go to WAIT_HI.
    - If tvalid[g]=0: stay in LOAD and keep the grant (no re-arbitration mid-packet).
  - WAIT_HI: tx_start returns to 0 after one cycle.
    - tx_busy=1 → WAIT_LO, counter cleared.
    - Otherwise the counter increments. On reaching ACK_TIMEOUT: pulse ack_err and go to WAIT_LO (treated as done).
  - WAIT_LO: when tx_busy=0:
    - last_flag=1 → last=idx, grant=0, active=0, go to IDLE.
    - last_flag=0 → go to LOAD.
- tready is asserted only in LOAD, so at most one byte is outstanding. No byte is accepted while tx_busy=1.
- Latency: tvalid rising in IDLE at cycle t → grant at t+1 → first tx_start (header or payload) at t+2.
- Single-beat packet (tvalid and tlast in the same beat): header + 1 byte, then release.
- Requests arriving while another channel holds the grant wait. tvalid on non-granted channels is ignored.
- Channel masking: the granted channel's tvalid/tlast are the only inputs sampled after arbitration.
- The release cycle (WAIT_LO → IDLE) never grants in the same cycle. Re-arbitration happens in IDLE one cycle later.

Test Plan:
- NUM_CH=4, ID_HEADER=1, ch2 sends 3-byte packet 0x11, 0x22, 0x33 (tlast on 0x33), serializer model busy for 10 cycles → tx_data sequence 0xA2, 0x11, 0x22, 0x33. Each tx_start is one cycle. grant=4'b0100 throughout, then returns to 0.
- ch0 and ch3 both request at the same cycle after reset, 1-byte packets each, both held valid → ch0 served first, then ch3. A further ch0+ch3 request is then served ch0 before ch3 again (last=3 makes ch0 next).
- ch1 holds the grant with 4-byte packet; ch0 asserts tvalid after byte 1 → ch0 tready stays 0 until ch1 tlast completes, then ch0 is granted.
- ch1 drops tvalid for 20 cycles mid-packet → grant stays ch1, no tx_start during the gap. Transfer resumes with the next byte.
- Serializer never raises tx_busy, ACK_TIMEOUT=16 → ack_err pulses exactly once 16 cycles after tx_start, and the FSM proceeds to the next byte.
- Assert rst during WAIT_LO of byte 2 of a 4-byte packet → next cycle grant=0, active=0, tx_start=0. A subsequent ch3 request is granted normally with the ch0-first pointer.
